// File: rtl/mm_pkg.sv
// Shared definitions for the matrix loader and its multiplier.
// Holds the loader FSM state encoding and the frame geometry (16 elements per
// matrix, 32 words per A+B frame) along with the derived index widths.
package mm_pkg;

    localparam int unsigned MAT_ELEMS   = 16;
    localparam int unsigned FRAME_WORDS = 2 * MAT_ELEMS;
    localparam int unsigned CNT_W       = $clog2(FRAME_WORDS);
    localparam int unsigned IDX_W       = $clog2(MAT_ELEMS);

    typedef enum logic [1:0] {
        LOAD_A    = 2'd0,
        LOAD_B    = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } mm_state_e;

endpackage

// File: rtl/matrix_loader.sv
// Streams a 32-word frame into two 4x4 operand buffers (A then B), then
// kicks the multiplier and holds the buffers until it reports done.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             gates word acceptance (loading stalls when low)
//   in_valid/in_ready  input handshake; in_data element, in_last frame end
//   matrix_a/matrix_b  flattened row-major operand buffers
//   mm_start/mm_done   one-cycle start pulse out, done pulse in
//   busy               frame in flight (first word until done)
//   frame_err          one-cycle pulse when in_last disagrees with word 31
module matrix_loader
    import mm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enable,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic signed [DATA_WIDTH-1:0]          in_data,
    input  logic                                  in_last,
    output logic signed [MAT_ELEMS*DATA_WIDTH-1:0] matrix_a,
    output logic signed [MAT_ELEMS*DATA_WIDTH-1:0] matrix_b,
    output logic                                  mm_start,
    input  logic                                  mm_done,
    output logic                                  busy,
    output logic                                  frame_err
);

    mm_state_e        state_q;
    mm_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rdy_q;
    logic             accept;
    logic             last_word;
    logic             err;
    logic             store_a;
    logic [IDX_W-1:0] idx;

    // rdy_q only rises on a clock edge, so in_ready stays low right after reset
    assign in_ready  = rdy_q & enable;
    assign accept    = in_valid & in_ready;
    assign last_word = (cnt_q == CNT_W'(FRAME_WORDS - 1));
    assign err       = accept & (in_last ^ last_word);
    assign store_a   = (cnt_q < CNT_W'(MAT_ELEMS));
    assign idx       = cnt_q[IDX_W-1:0];

    // State and word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD_A: begin
                if (accept) begin
                    if (err) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(MAT_ELEMS - 1)) begin
                            state_d = LOAD_B;
                        end
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    if (err) begin
                        cnt_d   = '0;
                        state_d = LOAD_A;
                    end else if (last_word) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (mm_done) begin
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = LOAD_A;
            end
        endcase
    end

    // Registered handshake/status outputs, all derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            mm_start  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rdy_q     <= (state_d == LOAD_A) || (state_d == LOAD_B);
            mm_start  <= (state_d == START);
            frame_err <= err;
            if (err) begin
                busy <= 1'b0;
            end else if (accept && (cnt_q == '0)) begin
                busy <= 1'b1;
            end else if ((state_q == WAIT_DONE) && mm_done) begin
                busy <= 1'b0;
            end
        end
    end

    // Operand buffers; only written on accepted words, so they are frozen
    // from mm_start until mm_done. A misframed word is still stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_a <= '0;
            matrix_b <= '0;
        end else if (accept) begin
            if (store_a) begin
                matrix_a[32'(idx) * DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end else begin
                matrix_b[32'(idx) * DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader. Frames sent intact are pushed to a
// scoreboard; on each mm_start the monitor pops 32 words and compares buffers.
module tb_matrix_loader;
    import mm_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned VW = MAT_ELEMS * W;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  in_data;
    logic                 in_last;
    logic signed [VW-1:0] matrix_a;
    logic signed [VW-1:0] matrix_b;
    logic                 mm_start;
    logic                 mm_done;
    logic                 busy;
    logic                 frame_err;

    int checks    = 0;
    int failures  = 0;
    int start_cnt = 0;
    int err_cnt   = 0;

    logic signed [W-1:0]  exp_q[$];
    logic signed [W-1:0]  fa[16];
    logic signed [W-1:0]  fb[16];
    logic signed [VW-1:0] sb_a;
    logic signed [VW-1:0] sb_b;

    matrix_loader #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .matrix_a (matrix_a),
        .matrix_b (matrix_b),
        .mm_start (mm_start),
        .mm_done  (mm_done),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: compare buffers against the oldest intact frame
    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (rst_n && mm_start) begin
            start_cnt++;
            checks++;
            if (exp_q.size() < 32) begin
                failures++;
                $display("FAIL sb_underflow: queued=%0d required>=32", exp_q.size());
            end else begin
                for (int k = 0; k < 16; k++) sb_a[k*W +: W] = exp_q.pop_front();
                for (int k = 0; k < 16; k++) sb_b[k*W +: W] = exp_q.pop_front();
                if (matrix_a !== sb_a) begin
                    failures++;
                    $display("FAIL sb_matrix_a: got=%h exp=%h", matrix_a, sb_a);
                end
                checks++;
                if (matrix_b !== sb_b) begin
                    failures++;
                    $display("FAIL sb_matrix_b: got=%h exp=%h", matrix_b, sb_b);
                end
            end
        end
    end

    task automatic push_frame();
        for (int k = 0; k < 16; k++) exp_q.push_back(fa[k]);
        for (int k = 0; k < 16; k++) exp_q.push_back(fb[k]);
    endtask

    // Offer one word from a negedge; returns at the negedge after acceptance
    task automatic send_word(input logic signed [W-1:0] d, input logic last);
        bit acc = 1'b0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            #1;
            acc = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL accept_timeout: in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic send_words(input int first, input int last_i, input int gap_max,
                              input int bad_last);
        for (int i = first; i <= last_i; i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_word((i < 16) ? fa[i] : fb[i-16], (i == 31) || (i == bad_last));
        end
    endtask

    // Called at the START negedge: hold done off, then pulse it
    task automatic finish_mm(input int hold);
        logic signed [VW-1:0] sa;
        logic signed [VW-1:0] sbv;
        @(negedge clk);
        checks++;
        if (mm_start !== 1'b0) begin
            failures++;
            $display("FAIL start_width: mm_start=%b required=0", mm_start);
        end
        sa  = matrix_a;
        sbv = matrix_b;
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL wait_hs: in_ready=%b busy=%b required 0/1", in_ready, busy);
            end
            checks++;
            if (matrix_a !== sa || matrix_b !== sbv) begin
                failures++;
                $display("FAIL wait_stable: a=%h b=%h exp a=%h b=%h", matrix_a, matrix_b, sa, sbv);
            end
            @(negedge clk);
        end
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_done: busy=%b in_ready=%b required 0/1", busy, in_ready);
        end
    endtask

    task automatic check_start_now(input string name);
        checks++;
        if (mm_start !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_start: mm_start=%b in_ready=%b required 1/0", name, mm_start, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; mm_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, mm_start, busy, frame_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: rdy/start/busy/err=%b required 0000",
                     {in_ready, mm_start, busy, frame_err});
        end
        checks++;
        if (matrix_a !== '0 || matrix_b !== '0) begin
            failures++;
            $display("FAIL reset_mats: a=%h b=%h required 0", matrix_a, matrix_b);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_early: in_ready=%b required 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_rise: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_identity();
        int s0 = start_cnt;
        for (int k = 0; k < 16; k++) begin
            fa[k] = W'(k + 1);
            fb[k] = ((k % 5) == 0) ? W'(1) : W'(0);
        end
        push_frame();
        send_words(0, 31, 0, -1);
        check_start_now("identity");
        finish_mm(4);
        checks++;
        if (start_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL identity_starts: count=%0d required 1", start_cnt - s0);
        end
    endtask

    task automatic test_gaps_enable();
        int s0 = start_cnt;
        for (int k = 0; k < 16; k++) begin
            fa[k] = W'($urandom);
            fb[k] = W'($urandom);
        end
        push_frame();
        send_words(0, 7, 2, -1);
        enable   = 1'b0;
        in_data  = fa[8];
        in_valid = 1'b1;
        repeat (3) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL stall: in_ready=%b busy=%b required 0/1", in_ready, busy);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        send_words(8, 31, 2, -1);
        check_start_now("gaps");
        finish_mm(2);
        checks++;
        if (start_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL gaps_starts: count=%0d required 1", start_cnt - s0);
        end
    endtask

    task automatic test_frame_err();
        int s0 = start_cnt;
        int e0 = err_cnt;
        for (int k = 0; k < 16; k++) begin
            fa[k] = W'($urandom);
            fb[k] = W'($urandom);
        end
        send_words(0, 20, 0, 20);
        checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse: frame_err=%b busy=%b required 1/0", frame_err, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt - e0 !== 1 || start_cnt !== s0) begin
            failures++;
            $display("FAIL err_count: errs=%0d starts=%0d required 1/0", err_cnt - e0, start_cnt - s0);
        end
        for (int k = 0; k < 16; k++) begin
            fa[k] = W'($urandom);
            fb[k] = W'($urandom);
        end
        push_frame();
        send_words(0, 31, 0, -1);
        check_start_now("err_next");
        finish_mm(0);
    endtask

    task automatic test_done_hold();
        int s0 = start_cnt;
        for (int k = 0; k < 16; k++) begin
            fa[k] = W'($urandom);
            fb[k] = W'($urandom);
        end
        push_frame();
        send_words(0, 4, 0, -1);
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || start_cnt !== s0) begin
            failures++;
            $display("FAIL done_in_load: in_ready=%b busy=%b starts=%0d required 1/1/0",
                     in_ready, busy, start_cnt - s0);
        end
        send_words(5, 31, 0, -1);
        check_start_now("done_hold");
        finish_mm(10);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 16; k++) begin
            fa[k] = W'($urandom_range(1, 1000));
            fb[k] = W'($urandom_range(1, 1000));
        end
        send_words(0, 24, 0, -1);
        in_data  = fb[9];
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        checks++;
        if ({in_ready, mm_start, busy, frame_err} !== 4'b0000 ||
            matrix_a !== '0 || matrix_b !== '0) begin
            failures++;
            $display("FAIL mid_reset: ctrl=%b a=%h b=%h required all 0",
                     {in_ready, mm_start, busy, frame_err}, matrix_a, matrix_b);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int k = 0; k < 16; k++) begin
            fa[k] = W'($urandom);
            fb[k] = -16'sd1;
        end
        push_frame();
        send_words(0, 31, 0, -1);
        check_start_now("after_reset");
        checks++;
        if (matrix_b[0 +: W] !== 16'hFFFF || matrix_b[15*W +: W] !== 16'hFFFF) begin
            failures++;
            $display("FAIL b_minus1: b0=%h b15=%h required ffff", matrix_b[0 +: W], matrix_b[15*W +: W]);
        end
        finish_mm(0);
    endtask

    task automatic test_back_to_back();
        bit acc = 1'b0;
        int acc_cyc = -1;
        for (int k = 0; k < 16; k++) begin
            fa[k] = W'($urandom);
            fb[k] = W'($urandom);
        end
        push_frame();
        send_words(0, 31, 0, -1);
        check_start_now("b2b_first");
        for (int k = 0; k < 16; k++) begin
            fa[k] = W'($urandom);
            fb[k] = W'($urandom);
        end
        push_frame();
        in_data  = fa[0];
        in_last  = 1'b0;
        in_valid = 1'b1;
        // mm_done is consumed at the rising edge of cycle 3
        for (int cyc = 0; cyc < 20 && !acc; cyc++) begin
            mm_done = (cyc == 3);
            #1;
            if (in_ready) begin
                acc     = 1'b1;
                acc_cyc = cyc;
            end
            @(negedge clk);
        end
        mm_done  = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (!acc || acc_cyc <= 3) begin
            failures++;
            $display("FAIL b2b_word0: accept_cycle=%0d required >3", acc_cyc);
        end
        send_words(1, 31, 0, -1);
        check_start_now("b2b_second");
        finish_mm(1);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_gaps_enable();
        test_frame_err();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0 || start_cnt !== 7) begin
            failures++;
            $display("FAIL final: queued=%0d starts=%0d required 0/7", exp_q.size(), start_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
